// File: rtl/seg7_pkg.sv
// Shared codes, segment constants and slot-state type for the seven-segment display blocks.
package seg7_pkg;
    localparam logic [4:0] SEG_CODE_DASH  = 5'b10000;
    localparam logic [4:0] SEG_CODE_BLANK = 5'b11111;
    localparam logic [6:0] SEG_OFF        = 7'h7F;
    localparam logic [6:0] SEG_DASH       = 7'h3F;

    typedef enum logic {
        SLOT_ON,
        SLOT_BLANK
    } slot_state_t;
endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit digit code -> active-low {g,f,e,d,c,b,a}; hex, dash, else blank.
// Zero latency, no flow control.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_n_o
);
    always_comb begin
        seg_n_o = SEG_OFF;
        unique case (code_i)
            5'h00:         seg_n_o = 7'h40;
            5'h01:         seg_n_o = 7'h79;
            5'h02:         seg_n_o = 7'h24;
            5'h03:         seg_n_o = 7'h30;
            5'h04:         seg_n_o = 7'h19;
            5'h05:         seg_n_o = 7'h12;
            5'h06:         seg_n_o = 7'h02;
            5'h07:         seg_n_o = 7'h78;
            5'h08:         seg_n_o = 7'h00;
            5'h09:         seg_n_o = 7'h10;
            5'h0A:         seg_n_o = 7'h08;
            5'h0B:         seg_n_o = 7'h03;
            5'h0C:         seg_n_o = 7'h46;
            5'h0D:         seg_n_o = 7'h21;
            5'h0E:         seg_n_o = 7'h06;
            5'h0F:         seg_n_o = 7'h0E;
            SEG_CODE_DASH: seg_n_o = SEG_DASH;
            default:       seg_n_o = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a per-frame latched 4-digit code word onto a common-anode display.
// Outputs registered, 1 clk behind the scan counters; free-running, no backpressure.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLKS_PER_DIGIT = 50000,
    parameter int BLANK_CLKS     = 500,
    parameter int BLINK_FRAMES   = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] bits,
    input  logic        blink,
    output logic [6:0]  seg_n,
    output logic [3:0]  dig_en_n,
    output logic        frame_done
);
    localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(CLKS_PER_DIGIT - BLANK_CLKS);
    localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [19:0]      shadow_q, shadow_d;
    logic             blink_phase_q, blink_phase_d;
    logic             dark_q, dark_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [3:0]       dig_en_n_q, dig_en_n_d;
    logic             frame_done_q, frame_done_d;

    logic [4:0]       cur_code;
    logic [6:0]       cur_seg_n;
    logic             wrap;
    logic             capture;
    slot_state_t      slot;

    always_comb begin
        cur_code = shadow_q[4:0];
        unique case (idx_q)
            2'd3: cur_code = shadow_q[19:15];
            2'd2: cur_code = shadow_q[14:10];
            2'd1: cur_code = shadow_q[9:5];
            2'd0: cur_code = shadow_q[4:0];
        endcase
    end

    seg7_decode u_decode (
        .code_i  (cur_code),
        .seg_n_o (cur_seg_n)
    );

    always_comb begin
        wrap          = (cnt_q == CNT_MAX);
        capture       = wrap && (idx_q == 2'd0);
        slot          = (cnt_q < ON_LIM) ? SLOT_ON : SLOT_BLANK;
        cnt_d         = wrap ? '0 : cnt_q + 1'b1;
        idx_d         = wrap ? idx_q - 2'd1 : idx_q;
        shadow_d      = capture ? bits : shadow_q;
        frame_done_d  = capture;
        blink_phase_d = blink_phase_q;
        frame_cnt_d   = frame_cnt_q;
        dark_d        = dark_q;

        if (!blink) begin
            blink_phase_d = 1'b0;
            frame_cnt_d   = '0;
        end else if (capture) begin
            if (frame_cnt_q == FC_MAX) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + 1'b1;
            end
        end
        // Darkness is sampled only at frame boundaries so a frame is never half lit.
        if (capture) begin
            dark_d = blink_phase_d;
        end

        seg_n_d    = SEG_OFF;
        dig_en_n_d = 4'hF;
        if (slot == SLOT_ON && !dark_q) begin
            seg_n_d    = cur_seg_n;
            dig_en_n_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd3;
            shadow_q      <= 20'hFFFFF;
            blink_phase_q <= 1'b0;
            dark_q        <= 1'b0;
            frame_cnt_q   <= '0;
            seg_n_q       <= SEG_OFF;
            dig_en_n_q    <= 4'hF;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            blink_phase_q <= blink_phase_d;
            dark_q        <= dark_d;
            frame_cnt_q   <= frame_cnt_d;
            seg_n_q       <= seg_n_d;
            dig_en_n_q    <= dig_en_n_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dig_en_n   = dig_en_n_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-clock slot, 2 dead clocks, 2-frame blink.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] bits = 20'h0;
    logic        blink = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  dig_en_n;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_driver #(
        .CLKS_PER_DIGIT (8),
        .BLANK_CLKS     (2),
        .BLINK_FRAMES   (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bits       (bits),
        .blink      (blink),
        .seg_n      (seg_n),
        .dig_en_n   (dig_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] bits;
        int          pos;
        logic [6:0]  seg;
        logic [3:0]  en;
    } vec_t;

    vec_t vq[$];

    localparam logic [19:0] BITS_A = 20'b01001_10000_10000_11111;
    localparam logic [19:0] BITS_Z = 20'h00000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Steps until frame_done is seen; returns the number of steps taken, -1 on timeout.
    task automatic wait_fd(input string name, output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (frame_done) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: frame_done not seen within 64 clks", name);
        end
    endtask

    task automatic chk_out(input string name, input logic [6:0] seg, input logic [3:0] en);
        chk({name, ".seg_n"}, 32'(seg_n), 32'(seg));
        chk({name, ".dig_en_n"}, 32'(dig_en_n), 32'(en));
    endtask

    initial begin
        logic [6:0] hex_tab [16];
        int n;
        vec_t v;

        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vq.push_back('{"a_d3_first", BITS_A, 0,  7'h10, 4'b0111});
        vq.push_back('{"a_d3_last",  BITS_A, 5,  7'h10, 4'b0111});
        vq.push_back('{"a_d3_dead0", BITS_A, 6,  7'h7F, 4'hF});
        vq.push_back('{"a_d3_dead1", BITS_A, 7,  7'h7F, 4'hF});
        vq.push_back('{"a_d2_dash",  BITS_A, 8,  7'h3F, 4'b1011});
        vq.push_back('{"a_d1_dash",  BITS_A, 16, 7'h3F, 4'b1101});
        vq.push_back('{"a_d0_blank", BITS_A, 24, 7'h7F, 4'b1110});
        vq.push_back('{"a_d0_dead",  BITS_A, 30, 7'h7F, 4'hF});
        vq.push_back('{"undef_d3",   20'b10101_00000_00000_00000, 0, 7'h7F, 4'b0111});
        vq.push_back('{"undef_d2",   20'b10101_00000_00000_00000, 8, 7'h40, 4'b1011});
        for (int h = 0; h < 16; h++) begin
            int d;
            d = h % 4;
            v.name = $sformatf("hex_%0h_d%0d", h, d);
            v.bits = 20'hFFFFF;
            v.bits[d*5 +: 5] = 5'(h);
            v.pos  = (3 - d) * 8 + 2;
            v.seg  = hex_tab[h];
            v.en   = ~(4'b0001 << d);
            vq.push_back(v);
        end

        // Reset and first (blank) frame.
        reset_n = 1'b0;
        step();
        chk_out("reset", 7'h7F, 4'hF);
        chk("reset.frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        bits    = BITS_A;
        step();
        chk_out("frame1_d3", 7'h7F, 4'b0111);
        wait_fd("first_fd", n);
        chk("first_fd_clks", 32'(n + 1), 32'd32);

        foreach (vq[i]) begin
            bits = vq[i].bits;
            wait_fd(vq[i].name, n);
            repeat (vq[i].pos + 1) step();
            chk_out(vq[i].name, vq[i].seg, vq[i].en);
        end

        // Mid-frame change of bits is held off until the next capture.
        bits = BITS_A;
        wait_fd("midchg_sync", n);
        repeat (9) step();
        bits = BITS_Z;
        repeat (16) step();
        chk_out("midchg_old_d0", 7'h7F, 4'b1110);
        wait_fd("midchg_fd", n);
        step();
        chk_out("midchg_new_d3", 7'h40, 4'b0111);

        // Blink: two frames lit, two dark, then release mid-dark.
        wait_fd("blink_sync", n);
        blink = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            logic lit;
            lit = (f == 1) || (f == 4) || (f == 5);
            wait_fd($sformatf("blink_f%0d_fd", f), n);
            repeat (2) step();
            if (lit) chk_out($sformatf("blink_f%0d_lit", f), 7'h40, 4'b0111);
            else     chk_out($sformatf("blink_f%0d_dark", f), 7'h7F, 4'hF);
        end
        repeat (8) step();
        blink = 1'b0;
        wait_fd("unblink_fd", n);
        repeat (2) step();
        chk_out("unblink_lit", 7'h40, 4'b0111);

        // Reset mid digit1 slot.
        wait_fd("rst_sync", n);
        repeat (18) step();
        reset_n = 1'b0;
        step();
        chk_out("midrst", 7'h7F, 4'hF);
        chk("midrst.frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        step();
        chk_out("midrst_restart_d3", 7'h7F, 4'b0111);
        wait_fd("midrst_fd", n);
        chk("midrst_fd_clks", 32'(n + 1), 32'd32);

        // frame_done width and period.
        step();
        chk("fd_width", 32'(frame_done), 32'd0);
        wait_fd("fd_period", n);
        chk("fd_period_clks", 32'(n + 1), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
